bram_stream_port: RTL and testbench
===================================

Name: bram_stream_port

Overview:
- Initiator for a single-port block RAM with a registered address: synchronous write, data readable one cycle after the address edge.
- Loads RAM contents from a byte stream (load mode), or streams RAM contents out as bytes (dump mode).
- Sits between a byte-wide host/debug link and a BlockRAM instance; drives its addr/wdata/we and samples its data.

Parameters:
- DataWidth, 8, RAM word width; must be a multiple of 8, at least 8; BytesPerWord = DataWidth/8.
- AddrWidth, 8, RAM address width; addresses wrap modulo 2**AddrWidth.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_start  in  1  one-cycle command strobe; sampled only in IDLE.
- cmd_mode  in  1  0 = load, 1 = dump.
- cmd_addr  in  AddrWidth  first word address.
- cmd_count  in  AddrWidth+1  number of words; 0 is legal.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at command completion.
- in_data  in  8  load byte stream.
- in_valid  in  1  in_data valid.
- in_ready  out  1  byte accepted when in_valid & in_ready.
- out_data  out  8  dump byte stream.
- out_valid  out  1  out_data valid.
- out_ready  in  1  byte consumed when out_valid & out_ready.
- ram_addr  out  AddrWidth  to RAM addr; always equals the internal cur_addr register.
- ram_wdata  out  DataWidth  to RAM wdata.
- ram_we  out  1  to RAM we.
- ram_rdata  in  DataWidth  from RAM data; valid the cycle after ram_addr is presented at an edge.

Behaviour:
- Reset (async, rst_n=0) values: state IDLE; cur_addr, remaining, byte_idx, word buffer all 0; busy=0, done=0, in_ready=0, out_valid=0, out_data=0, ram_we=0, ram_wdata=0, ram_addr=0.
- Reset mid-command aborts it with no further RAM writes. Words already written stay written. A partially assembled word is discarded.
- IDLE:
  - On cmd_start, latch cur_addr=cmd_addr, remaining=cmd_count, byte_idx=0.
  - If cmd_count==0, go to DONE; otherwise go to LOAD_COLLECT (mode 0) or DUMP_ADDR (mode 1).
  - cmd_start outside IDLE is ignored.
- LOAD_COLLECT:
  - in_ready=1.
  - Each accepted byte goes into byte lane byte_idx of the word buffer, little-endian (first byte = bits 7:0); byte_idx increments.
  - Accepting byte BytesPerWord-1 sets byte_idx=0 and moves to LOAD_WRITE.
- LOAD_WRITE:
  - ram_we=1 and ram_wdata=buffer for exactly one cycle, with ram_addr=cur_addr; the write commits at that edge. in_ready=0.
  - Then cur_addr+=1 (wrapping) and remaining-=1.
  - If remaining becomes 0, go to DONE; otherwise go to LOAD_COLLECT.
  - Throughput: BytesPerWord+1 cycles per word minimum.
- DUMP_ADDR: ram_addr=cur_addr is registered by the RAM at this edge; go to DUMP_WAIT.
- DUMP_WAIT: capture ram_rdata into the shift buffer; go to DUMP_SEND.
- DUMP_SEND:
  - out_valid=1 and out_data=buffer[7:0]; both are held stable while out_ready=0.
  - On handshake, the buffer shifts right 8 and byte_idx increments.
  - After the last byte: byte_idx=0, cur_addr+=1, remaining-=1, then go to DUMP_ADDR or DONE.
  - out_valid deasserts in the cycle after the last handshake.
- DONE: done=1 for one cycle; busy=1; then IDLE.
- ram_we is 0 in every state except LOAD_WRITE; dump mode never writes.
- Wrap-around: the address after 2**AddrWidth-1 is 0. count=2**AddrWidth covers the whole RAM exactly once.
- in_ready and out_valid never assert in IDLE or DONE.

Decomposition:
- Shared package holds:
  - state encoding: IDLE, LOAD_COLLECT, LOAD_WRITE, DUMP_ADDR, DUMP_WAIT, DUMP_SEND, DONE;
  - MODE_LOAD=0, MODE_DUMP=1 constants;
  - BytesPerWord derivation.
- One shift-buffer register serves both packing and unpacking; no sub-module is required.
- The bench instantiates this block together with BlockRAM.

Test Plan (DataWidth=16, AddrWidth=4, unless stated):
- Load: start mode 0, addr 3, count 2, bytes 34 12 78 56 with in_valid held high -> ram_we pulses twice (addr 3 data 1234, addr 4 data 5678), each exactly one cycle; done one cycle after the second write; busy falls with done.
- Dump: after the load, start mode 1, addr 3, count 2; out_ready toggles 1,0,1,0 -> bytes 34 12 78 56 in order; out_data stable during stalls; ram_we never asserted; done pulse after the last handshake.
- Wrap: load addr 15, count 2, bytes AA BB CC DD -> writes BBAA at 15 and DDCC at 0; then dump addr 15, count 2 returns AA BB CC DD.
- Zero count: start with count 0 -> busy high for 1 cycle (DONE), done pulse; in_ready, out_valid and ram_we stay 0.
- Reset mid-load: rst_n low after 1 byte of a word -> all outputs are reset values immediately; RAM is unchanged; a new load addr 0, count 1, bytes 01 02 writes 0201 at 0 (no stale byte).
- Busy guard: a second cmd_start during a dump of count 3 is ignored -> exactly 6 bytes out, one done pulse.

Source files
------------

// File: rtl/bram_stream_port_pkg.sv
// Shared definitions for the byte-stream to block-RAM port: state encoding,
// command mode constants and word/byte geometry helpers.
package bram_stream_port_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoadCollect,
    StLoadWrite,
    StDumpAddr,
    StDumpWait,
    StDumpSend,
    StDone
  } state_e;

  localparam logic ModeLoad = 1'b0;
  localparam logic ModeDump = 1'b1;

  function automatic int unsigned bytes_per_word(input int unsigned data_width);
    return data_width / 8;
  endfunction

  // A single-byte word still needs a one-bit lane index to keep widths legal.
  function automatic int unsigned idx_width(input int unsigned bpw);
    return (bpw > 1) ? $clog2(bpw) : 1;
  endfunction

endpackage

// File: rtl/bram_stream_port.sv
// Byte-stream initiator for a registered-address single-port block RAM:
// packs incoming bytes into words and writes them (load), or reads words and streams bytes out (dump).
module bram_stream_port
  import bram_stream_port_pkg::*;
#(
  parameter int unsigned DataWidth = 8,
  parameter int unsigned AddrWidth = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_cmd_start,
  input  logic                 i_cmd_mode,
  input  logic [AddrWidth-1:0] i_cmd_addr,
  input  logic [AddrWidth:0]   i_cmd_count,
  output logic                 o_busy,
  output logic                 o_done,
  input  logic [7:0]           i_in_data,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  output logic [7:0]           o_out_data,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic [AddrWidth-1:0] o_ram_addr,
  output logic [DataWidth-1:0] o_ram_wdata,
  output logic                 o_ram_we,
  input  logic [DataWidth-1:0] i_ram_rdata
);

  localparam int unsigned BytesPerWord = bytes_per_word(DataWidth);
  localparam int unsigned IdxWidth     = idx_width(BytesPerWord);
  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(BytesPerWord - 1);

  state_e               r_state;
  logic [AddrWidth-1:0] r_cur_addr;
  logic [AddrWidth:0]   r_remaining;
  logic [IdxWidth-1:0]  r_byte_idx;
  logic [DataWidth-1:0] r_buf;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic                 r_ram_we;

  logic w_in_fire;
  logic w_out_fire;
  logic w_last_byte;
  logic w_last_word;

  assign w_in_fire   = i_in_valid & r_in_ready;
  assign w_out_fire  = r_out_valid & i_out_ready;
  assign w_last_byte = (r_byte_idx == LastIdx);
  assign w_last_word = (r_remaining == (AddrWidth + 1)'(1));

  // One buffer packs on load (lane writes) and unpacks on dump (right shifts).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_cur_addr  <= '0;
      r_remaining <= '0;
      r_byte_idx  <= '0;
      r_buf       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_ram_we    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_cmd_start) begin
            r_cur_addr  <= i_cmd_addr;
            r_remaining <= i_cmd_count;
            r_byte_idx  <= '0;
            r_busy      <= 1'b1;
            if (i_cmd_count == '0) begin
              r_state <= StDone;
              r_done  <= 1'b1;
            end else if (i_cmd_mode == ModeLoad) begin
              r_state    <= StLoadCollect;
              r_in_ready <= 1'b1;
            end else begin
              r_state <= StDumpAddr;
            end
          end
        end

        StLoadCollect: begin
          if (w_in_fire) begin
            for (int i = 0; i < int'(BytesPerWord); i++) begin
              if (r_byte_idx == IdxWidth'(i)) begin
                r_buf[i*8 +: 8] <= i_in_data;
              end
            end
            if (w_last_byte) begin
              r_byte_idx <= '0;
              r_in_ready <= 1'b0;
              r_ram_we   <= 1'b1;
              r_state    <= StLoadWrite;
            end else begin
              r_byte_idx <= r_byte_idx + 1'b1;
            end
          end
        end

        StLoadWrite: begin
          r_ram_we    <= 1'b0;
          r_cur_addr  <= r_cur_addr + 1'b1;
          r_remaining <= r_remaining - 1'b1;
          if (w_last_word) begin
            r_state <= StDone;
            r_done  <= 1'b1;
          end else begin
            r_state    <= StLoadCollect;
            r_in_ready <= 1'b1;
          end
        end

        // RAM registers r_cur_addr at the edge leaving this state.
        StDumpAddr: begin
          r_state <= StDumpWait;
        end

        StDumpWait: begin
          r_buf       <= i_ram_rdata;
          r_out_valid <= 1'b1;
          r_state     <= StDumpSend;
        end

        StDumpSend: begin
          if (w_out_fire) begin
            r_buf <= r_buf >> 8;
            if (w_last_byte) begin
              r_byte_idx  <= '0;
              r_cur_addr  <= r_cur_addr + 1'b1;
              r_remaining <= r_remaining - 1'b1;
              r_out_valid <= 1'b0;
              if (w_last_word) begin
                r_state <= StDone;
                r_done  <= 1'b1;
              end else begin
                r_state <= StDumpAddr;
              end
            end else begin
              r_byte_idx <= r_byte_idx + 1'b1;
            end
          end
        end

        StDone: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end

        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_buf[7:0];
  assign o_ram_addr  = r_cur_addr;
  assign o_ram_we    = r_ram_we;
  assign o_ram_wdata = r_ram_we ? r_buf : '0;

endmodule

// File: tb/tb_bram_stream_port.sv
// Scoreboard bench for bram_stream_port with a registered-address RAM model;
// directed load/dump/wrap/zero/reset/busy-guard scenarios.
module tb_bram_stream_port;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_start;
  logic          cmd_mode;
  logic [AW-1:0] cmd_addr;
  logic [AW:0]   cmd_count;
  logic          busy;
  logic          done;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_we;
  logic [DW-1:0] ram_rdata;

  always #5 clk = ~clk;

  bram_stream_port #(
    .DataWidth(DW),
    .AddrWidth(AW)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_cmd_start(cmd_start),
    .i_cmd_mode (cmd_mode),
    .i_cmd_addr (cmd_addr),
    .i_cmd_count(cmd_count),
    .o_busy     (busy),
    .o_done     (done),
    .i_in_data  (in_data),
    .i_in_valid (in_valid),
    .o_in_ready (in_ready),
    .o_out_data (out_data),
    .o_out_valid(out_valid),
    .i_out_ready(out_ready),
    .o_ram_addr (ram_addr),
    .o_ram_wdata(ram_wdata),
    .o_ram_we   (ram_we),
    .i_ram_rdata(ram_rdata)
  );

  // Block RAM: synchronous write, registered address, data valid one cycle later.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [AW-1:0] ram_addr_q;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_addr_q <= ram_addr;
  end
  assign ram_rdata = mem[ram_addr_q];

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t        exp_wr[$];
  logic [7:0] exp_byte[$];
  int         n_checks = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         done_cnt = 0;
  int         last_we_cyc = -10;
  int         last_hs_cyc = -10;
  logic       prev_we = 1'b0;
  logic       prev_done = 1'b0;
  logic       hold_valid = 1'b0;
  logic [7:0] hold_data = 8'h00;
  logic       toggle = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = toggle ? ~out_ready : 1'b1;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT writes RAM or hands off a byte.
  always @(negedge clk) begin
    wr_t        e;
    logic [7:0] b;
    if (rst_n) begin
      if (ram_we) begin
        if (exp_wr.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_write: addr %0h data %0h, no write expected", ram_addr,
                   ram_wdata);
        end else begin
          e = exp_wr.pop_front();
          chk("wr_addr", 32'(ram_addr), 32'(e.a));
          chk("wr_data", 32'(ram_wdata), 32'(e.d));
        end
        chk("we_one_cycle", 32'(prev_we), 0);
        last_we_cyc = cyc;
      end
      prev_we = ram_we;
      if (out_valid && hold_valid) chk("out_stable", 32'(out_data), 32'(hold_data));
      hold_valid = out_valid && !out_ready;
      hold_data  = out_data;
      if (out_valid && out_ready) begin
        if (exp_byte.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_byte: got %0h, no byte expected", out_data);
        end else begin
          b = exp_byte.pop_front();
          chk("out_byte", 32'(out_data), 32'(b));
        end
        last_hs_cyc = cyc;
      end
      if (done) begin
        chk("done_one_cycle", 32'(prev_done), 0);
        done_cnt++;
      end
      prev_done = done;
    end else begin
      prev_we    = 1'b0;
      prev_done  = 1'b0;
      hold_valid = 1'b0;
    end
  end

  task automatic start_cmd(input logic mode, input logic [AW-1:0] addr, input logic [AW:0] cnt);
    @(posedge clk);
    #1;
    cmd_start = 1'b1;
    cmd_mode  = mode;
    cmd_addr  = addr;
    cmd_count = cnt;
    @(posedge clk);
    #1;
    cmd_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_checks++;
      n_err++;
      $display("FAIL in_ready_timeout: byte %0h never accepted", b);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int dcyc);
    int t = 0;
    @(negedge clk);
    while (!done && t < 200) begin
      @(negedge clk);
      t++;
    end
    dcyc = cyc;
    chk("done_seen", 32'(done), 1);
    chk("busy_with_done", 32'(busy), 1);
    @(negedge clk);
    chk("busy_after_done", 32'(busy), 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_in_ready"}, 32'(in_ready), 0);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_out_data"}, 32'(out_data), 0);
    chk({tag, "_ram_we"}, 32'(ram_we), 0);
    chk({tag, "_ram_wdata"}, 32'(ram_wdata), 0);
    chk({tag, "_ram_addr"}, 32'(ram_addr), 0);
  endtask

  initial begin
    int d;
    rst_n     = 1'b0;
    cmd_start = 1'b0;
    cmd_mode  = 1'b0;
    cmd_addr  = '0;
    cmd_count = '0;
    in_data   = '0;
    in_valid  = 1'b0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Load addr 3, count 2.
    exp_wr.push_back('{a: 4'd3, d: 16'h1234});
    exp_wr.push_back('{a: 4'd4, d: 16'h5678});
    start_cmd(1'b0, 4'd3, 5'd2);
    send_byte(8'h34);
    send_byte(8'h12);
    send_byte(8'h78);
    send_byte(8'h56);
    in_valid = 1'b0;
    wait_done(d);
    chk("load_done_after_write", 32'(d), 32'(last_we_cyc + 1));
    chk("load_wr_left", 32'(exp_wr.size()), 0);
    chk("load_done_cnt", 32'(done_cnt), 1);

    // Dump addr 3, count 2 with out_ready toggling.
    toggle = 1'b1;
    exp_byte.push_back(8'h34);
    exp_byte.push_back(8'h12);
    exp_byte.push_back(8'h78);
    exp_byte.push_back(8'h56);
    start_cmd(1'b1, 4'd3, 5'd2);
    wait_done(d);
    toggle = 1'b0;
    chk("dump_done_after_hs", 32'(d), 32'(last_hs_cyc + 1));
    chk("dump_bytes_left", 32'(exp_byte.size()), 0);
    chk("dump_done_cnt", 32'(done_cnt), 2);

    // Wrap-around load then dump.
    exp_wr.push_back('{a: 4'd15, d: 16'hBBAA});
    exp_wr.push_back('{a: 4'd0, d: 16'hDDCC});
    start_cmd(1'b0, 4'd15, 5'd2);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    send_byte(8'hDD);
    in_valid = 1'b0;
    wait_done(d);
    chk("wrap_wr_left", 32'(exp_wr.size()), 0);
    exp_byte.push_back(8'hAA);
    exp_byte.push_back(8'hBB);
    exp_byte.push_back(8'hCC);
    exp_byte.push_back(8'hDD);
    start_cmd(1'b1, 4'd15, 5'd2);
    wait_done(d);
    chk("wrap_bytes_left", 32'(exp_byte.size()), 0);
    chk("wrap_done_cnt", 32'(done_cnt), 4);

    // Zero count: straight to DONE.
    start_cmd(1'b0, 4'd5, 5'd0);
    @(negedge clk);
    chk("zero_busy", 32'(busy), 1);
    chk("zero_done", 32'(done), 1);
    chk("zero_in_ready", 32'(in_ready), 0);
    chk("zero_out_valid", 32'(out_valid), 0);
    chk("zero_ram_we", 32'(ram_we), 0);
    @(negedge clk);
    chk("zero_busy_after", 32'(busy), 0);
    chk("zero_done_after", 32'(done), 0);
    chk("zero_done_cnt", 32'(done_cnt), 5);

    // Reset after one byte of a word.
    start_cmd(1'b0, 4'd0, 5'd1);
    send_byte(8'h99);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midrst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("midrst_mem0", 32'(mem[0]), 32'h0000DDCC);
    chk("midrst_mem15", 32'(mem[15]), 32'h0000BBAA);
    exp_wr.push_back('{a: 4'd0, d: 16'h0201});
    start_cmd(1'b0, 4'd0, 5'd1);
    send_byte(8'h01);
    send_byte(8'h02);
    in_valid = 1'b0;
    wait_done(d);
    chk("midrst_wr_left", 32'(exp_wr.size()), 0);
    chk("midrst_done_cnt", 32'(done_cnt), 6);

    // Second cmd_start during a busy dump is ignored.
    exp_byte.push_back(8'h34);
    exp_byte.push_back(8'h12);
    exp_byte.push_back(8'h78);
    exp_byte.push_back(8'h56);
    exp_byte.push_back(8'h00);
    exp_byte.push_back(8'h00);
    start_cmd(1'b1, 4'd3, 5'd3);
    @(posedge clk);
    #1;
    cmd_start = 1'b1;
    cmd_mode  = 1'b0;
    cmd_addr  = 4'd9;
    cmd_count = 5'd5;
    @(posedge clk);
    #1;
    cmd_start = 1'b0;
    wait_done(d);
    repeat (12) @(negedge clk);
    chk("guard_bytes_left", 32'(exp_byte.size()), 0);
    chk("guard_done_cnt", 32'(done_cnt), 7);
    chk("guard_busy_idle", 32'(busy), 0);
    chk("guard_in_ready", 32'(in_ready), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
